// File: rtl/l2_input_arbiter.sv
// L2 input arbiter: three 2-entry channel FIFOs (rsp/fwd/cpu) feeding the core with
// fixed priority rsp > fwd > cpu, stall gating and an aging override for CPU requests.

`ifndef COH_MSG_TYPE_WIDTH
`define COH_MSG_TYPE_WIDTH 2
`endif
`ifndef INVACK_CNT_WIDTH
`define INVACK_CNT_WIDTH 4
`endif
`ifndef MIX_MSG_TYPE_WIDTH
`define MIX_MSG_TYPE_WIDTH 3
`endif
`ifndef CACHE_ID_WIDTH
`define CACHE_ID_WIDTH 4
`endif
`ifndef CPU_MSG_TYPE_WIDTH
`define CPU_MSG_TYPE_WIDTH 2
`endif
`ifndef HSIZE_WIDTH
`define HSIZE_WIDTH 3
`endif
`ifndef HPROT_WIDTH
`define HPROT_WIDTH 2
`endif

module l2_arb_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         ready,
    output logic         nonempty,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Ready depends only on the registered count: no accept-on-pop when full.
    assign ready    = (count != 2'd2);
    assign nonempty = (count != 2'd0);
    assign head     = mem[rd_ptr];
endmodule

module l2_input_arbiter #(
    parameter int ADDR_BITS      = 32,
    parameter int LINE_ADDR_BITS = 28,
    parameter int BITS_PER_WORD  = 32,
    parameter int BITS_PER_LINE  = 128,
    parameter int AGE_MAX        = 15,
    localparam int RSP_W = `COH_MSG_TYPE_WIDTH + LINE_ADDR_BITS + BITS_PER_LINE + `INVACK_CNT_WIDTH,
    localparam int FWD_W = `MIX_MSG_TYPE_WIDTH + LINE_ADDR_BITS + `CACHE_ID_WIDTH,
    localparam int CPU_W = `CPU_MSG_TYPE_WIDTH + `HSIZE_WIDTH + `HPROT_WIDTH + ADDR_BITS + BITS_PER_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rsp_in_valid,
    output logic             rsp_in_ready,
    input  logic [RSP_W-1:0] rsp_in_data,
    input  logic             fwd_in_valid,
    output logic             fwd_in_ready,
    input  logic [FWD_W-1:0] fwd_in_data,
    input  logic             cpu_req_valid,
    output logic             cpu_req_ready,
    input  logic [CPU_W-1:0] cpu_req_data,
    input  logic             fwd_stall,
    input  logic             cpu_stall,
    output logic             sel_valid,
    input  logic             sel_ready,
    output logic [1:0]       sel_kind,
    output logic [RSP_W-1:0] sel_rsp_data,
    output logic [FWD_W-1:0] sel_fwd_data,
    output logic [CPU_W-1:0] sel_cpu_data
);
    localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);
    localparam logic [1:0] K_NONE = 2'd0, K_RSP = 2'd1, K_FWD = 2'd2, K_CPU = 2'd3;

    logic       rsp_ne, fwd_ne, cpu_ne;
    logic       rsp_elig, fwd_elig, cpu_elig;
    logic       hs, rsp_pop, fwd_pop, cpu_pop;
    logic [3:0] age;

    l2_arb_fifo #(.W(RSP_W)) u_rsp_fifo (
        .clk(clk), .rst(rst), .push(rsp_in_valid && rsp_in_ready), .din(rsp_in_data),
        .pop(rsp_pop), .ready(rsp_in_ready), .nonempty(rsp_ne), .head(sel_rsp_data)
    );

    l2_arb_fifo #(.W(FWD_W)) u_fwd_fifo (
        .clk(clk), .rst(rst), .push(fwd_in_valid && fwd_in_ready), .din(fwd_in_data),
        .pop(fwd_pop), .ready(fwd_in_ready), .nonempty(fwd_ne), .head(sel_fwd_data)
    );

    l2_arb_fifo #(.W(CPU_W)) u_cpu_fifo (
        .clk(clk), .rst(rst), .push(cpu_req_valid && cpu_req_ready), .din(cpu_req_data),
        .pop(cpu_pop), .ready(cpu_req_ready), .nonempty(cpu_ne), .head(sel_cpu_data)
    );

    assign rsp_elig = rsp_ne;
    assign fwd_elig = fwd_ne && !fwd_stall;
    assign cpu_elig = cpu_ne && !cpu_stall;

    always_comb begin
        sel_kind = K_NONE;
        if (cpu_elig && age == AGE_LIM)
            sel_kind = K_CPU;
        else if (rsp_elig)
            sel_kind = K_RSP;
        else if (fwd_elig)
            sel_kind = K_FWD;
        else if (cpu_elig)
            sel_kind = K_CPU;
    end

    assign sel_valid = (sel_kind != K_NONE);
    assign hs        = sel_valid && sel_ready;
    assign rsp_pop   = hs && sel_kind == K_RSP;
    assign fwd_pop   = hs && sel_kind == K_FWD;
    assign cpu_pop   = hs && sel_kind == K_CPU;

    // Age counts grants lost by a waiting CPU request to rsp/fwd traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            age <= 4'd0;
        else if (!cpu_elig || cpu_pop)
            age <= 4'd0;
        else if ((rsp_pop || fwd_pop) && age != AGE_LIM)
            age <= age + 4'd1;
    end
endmodule

// File: tb/tb_l2_input_arbiter.sv
// Randomized and directed bench for l2_input_arbiter with a queue-based reference model.

`ifndef COH_MSG_TYPE_WIDTH
`define COH_MSG_TYPE_WIDTH 2
`endif
`ifndef INVACK_CNT_WIDTH
`define INVACK_CNT_WIDTH 4
`endif
`ifndef MIX_MSG_TYPE_WIDTH
`define MIX_MSG_TYPE_WIDTH 3
`endif
`ifndef CACHE_ID_WIDTH
`define CACHE_ID_WIDTH 4
`endif
`ifndef CPU_MSG_TYPE_WIDTH
`define CPU_MSG_TYPE_WIDTH 2
`endif
`ifndef HSIZE_WIDTH
`define HSIZE_WIDTH 3
`endif
`ifndef HPROT_WIDTH
`define HPROT_WIDTH 2
`endif

module tb_l2_input_arbiter;
    localparam int ADDR_BITS = 32, LINE_ADDR_BITS = 28, BITS_PER_WORD = 32, BITS_PER_LINE = 128;
    localparam int AGE_MAX = 15;
    localparam int INV_W = `INVACK_CNT_WIDTH;
    localparam int CID_W = `CACHE_ID_WIDTH;
    localparam int RSP_W = `COH_MSG_TYPE_WIDTH + LINE_ADDR_BITS + BITS_PER_LINE + INV_W;
    localparam int FWD_W = `MIX_MSG_TYPE_WIDTH + LINE_ADDR_BITS + CID_W;
    localparam int CPU_W = `CPU_MSG_TYPE_WIDTH + `HSIZE_WIDTH + `HPROT_WIDTH + ADDR_BITS + BITS_PER_WORD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rsp_in_valid = 1'b0, fwd_in_valid = 1'b0, cpu_req_valid = 1'b0;
    logic rsp_in_ready, fwd_in_ready, cpu_req_ready;
    logic [RSP_W-1:0] rsp_in_data = '0;
    logic [FWD_W-1:0] fwd_in_data = '0;
    logic [CPU_W-1:0] cpu_req_data = '0;
    logic fwd_stall = 1'b0, cpu_stall = 1'b0, sel_ready = 1'b0;
    logic sel_valid;
    logic [1:0] sel_kind;
    logic [RSP_W-1:0] sel_rsp_data;
    logic [FWD_W-1:0] sel_fwd_data;
    logic [CPU_W-1:0] sel_cpu_data;

    int checks = 0;
    int errors = 0;

    logic [RSP_W-1:0] rq[$];
    logic [FWD_W-1:0] fq[$];
    logic [CPU_W-1:0] cq[$];
    int age = 0;
    logic [1:0] grant_log[$];
    logic [BITS_PER_WORD-1:0] cpu_log[$];

    always #5 clk = ~clk;

    l2_input_arbiter #(
        .ADDR_BITS(ADDR_BITS), .LINE_ADDR_BITS(LINE_ADDR_BITS), .BITS_PER_WORD(BITS_PER_WORD),
        .BITS_PER_LINE(BITS_PER_LINE), .AGE_MAX(AGE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .rsp_in_valid(rsp_in_valid), .rsp_in_ready(rsp_in_ready), .rsp_in_data(rsp_in_data),
        .fwd_in_valid(fwd_in_valid), .fwd_in_ready(fwd_in_ready), .fwd_in_data(fwd_in_data),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_data(cpu_req_data),
        .fwd_stall(fwd_stall), .cpu_stall(cpu_stall),
        .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_kind(sel_kind),
        .sel_rsp_data(sel_rsp_data), .sel_fwd_data(sel_fwd_data), .sel_cpu_data(sel_cpu_data)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RSP_W-1:0] rnd_rsp();
        logic [191:0] t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[RSP_W-1:0];
    endfunction
    function automatic logic [FWD_W-1:0] rnd_fwd();
        logic [63:0] t = {$urandom, $urandom};
        return t[FWD_W-1:0];
    endfunction
    function automatic logic [CPU_W-1:0] rnd_cpu();
        logic [95:0] t = {$urandom, $urandom, $urandom};
        return t[CPU_W-1:0];
    endfunction

    // Monitor / reference model: predicts readiness and selection from queue contents.
    initial begin : monitor
        logic [1:0] ek, pk;
        bit re, fe, ce, pr, pf, pc;
        logic [RSP_W-1:0] dr;
        logic [FWD_W-1:0] df;
        logic [CPU_W-1:0] dc;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("reset_ready", 256'({rsp_in_ready, fwd_in_ready, cpu_req_ready}), 256'(3'b111));
                chk("reset_sel", 256'({sel_valid, sel_kind}), 256'(3'b000));
                rq.delete(); fq.delete(); cq.delete();
                age = 0;
            end else begin
                chk("in_ready", 256'({rsp_in_ready, fwd_in_ready, cpu_req_ready}),
                    256'({rq.size() < 2, fq.size() < 2, cq.size() < 2}));
                re = rq.size() > 0;
                fe = fq.size() > 0 && !fwd_stall;
                ce = cq.size() > 0 && !cpu_stall;
                if (ce && age == AGE_MAX) ek = 2'd3;
                else if (re) ek = 2'd1;
                else if (fe) ek = 2'd2;
                else if (ce) ek = 2'd3;
                else ek = 2'd0;
                chk("sel_kind", 256'(sel_kind), 256'(ek));
                chk("sel_valid", 256'(sel_valid), 256'(ek != 2'd0));
                if (rq.size() > 0) chk("rsp_head", 256'(sel_rsp_data), 256'(rq[0]));
                if (fq.size() > 0) chk("fwd_head", 256'(sel_fwd_data), 256'(fq[0]));
                if (cq.size() > 0) chk("cpu_head", 256'(sel_cpu_data), 256'(cq[0]));
                pr = rsp_in_valid && rq.size() < 2;  dr = rsp_in_data;
                pf = fwd_in_valid && fq.size() < 2;  df = fwd_in_data;
                pc = cpu_req_valid && cq.size() < 2; dc = cpu_req_data;
                pk = sel_ready ? ek : 2'd0;
                @(posedge clk);
                if (rst) begin
                    if (pk != 2'd0) grant_log.push_back(pk);
                    case (pk)
                        2'd1: void'(rq.pop_front());
                        2'd2: void'(fq.pop_front());
                        2'd3: begin
                            cpu_log.push_back(cq[0][BITS_PER_WORD-1:0]);
                            void'(cq.pop_front());
                        end
                        default: ;
                    endcase
                    if (!ce || pk == 2'd3) age = 0;
                    else if ((pk == 2'd1 || pk == 2'd2) && age < AGE_MAX) age = age + 1;
                    if (pr) rq.push_back(dr);
                    if (pf) fq.push_back(df);
                    if (pc) cq.push_back(dc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rsp_in_valid = 1'b0; fwd_in_valid = 1'b0; cpu_req_valid = 1'b0;
        fwd_stall = 1'b0; cpu_stall = 1'b0;
    endtask

    initial begin : stimulus
        int idx;
        bit acc;
        // Power-on reset
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Priority: all three pushed together, drained rsp, fwd, cpu
        grant_log.delete();
        rsp_in_data = '0; rsp_in_data[INV_W + BITS_PER_LINE +: LINE_ADDR_BITS] = 28'h10;
        fwd_in_data = '0; fwd_in_data[CID_W +: LINE_ADDR_BITS] = 28'h20;
        cpu_req_data = '0; cpu_req_data[BITS_PER_WORD +: ADDR_BITS] = 32'h300;
        rsp_in_valid = 1'b1; fwd_in_valid = 1'b1; cpu_req_valid = 1'b1; sel_ready = 1'b1;
        tick();
        idle_inputs();
        repeat (4) tick();
        chk("prio_count", 256'(grant_log.size()), 256'(3));
        if (grant_log.size() == 3) begin
            chk("prio_first", 256'(grant_log[0]), 256'(2'd1));
            chk("prio_second", 256'(grant_log[1]), 256'(2'd2));
            chk("prio_third", 256'(grant_log[2]), 256'(2'd3));
        end

        // Stall: stalled fwd lets cpu through, unstall gives fwd priority again
        sel_ready = 1'b0; fwd_stall = 1'b1;
        fwd_in_data = rnd_fwd(); cpu_req_data = rnd_cpu();
        fwd_in_valid = 1'b1; cpu_req_valid = 1'b1;
        tick();
        fwd_in_valid = 1'b0; cpu_req_valid = 1'b0;
        @(negedge clk);
        chk("stall_cpu_kind", 256'(sel_kind), 256'(2'd3));
        tick();
        fwd_stall = 1'b0;
        @(negedge clk);
        chk("unstall_fwd_kind", 256'(sel_kind), 256'(2'd2));
        tick();
        sel_ready = 1'b1;
        repeat (3) tick();

        // Full: third forward waits for a pop and is taken the cycle after it
        sel_ready = 1'b0;
        fwd_in_valid = 1'b1; fwd_in_data = rnd_fwd();
        tick();
        fwd_in_data = rnd_fwd();
        tick();
        fwd_in_data = rnd_fwd();
        @(negedge clk);
        chk("full_ready0", 256'(fwd_in_ready), 256'(1'b0));
        tick();
        @(negedge clk);
        chk("full_ready1", 256'(fwd_in_ready), 256'(1'b0));
        tick();
        sel_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_same_cycle", 256'(fwd_in_ready), 256'(1'b0));
        tick();
        sel_ready = 1'b0;
        @(negedge clk);
        chk("full_after_pop", 256'(fwd_in_ready), 256'(1'b1));
        tick();
        fwd_in_valid = 1'b0;
        @(negedge clk);
        chk("full_refilled", 256'(fwd_in_ready), 256'(1'b0));
        tick();
        sel_ready = 1'b1;
        repeat (3) tick();

        // Aging: a CPU request under a continuous rsp stream wins after AGE_MAX losses
        grant_log.delete();
        cpu_req_data = rnd_cpu(); cpu_req_valid = 1'b1;
        rsp_in_valid = 1'b1; rsp_in_data = rnd_rsp();
        tick();
        cpu_req_valid = 1'b0;
        idx = 0;
        while (idx < 60 && !(grant_log.size() > 0 && grant_log[grant_log.size()-1] == 2'd3)) begin
            rsp_in_data = rnd_rsp();
            tick();
            idx++;
        end
        chk("age_cpu_granted", 256'(idx < 60), 256'(1'b1));
        chk("age_rsp_before_cpu", 256'(grant_log.size()), 256'(AGE_MAX + 1));
        rsp_in_data = rnd_rsp();
        tick();
        rsp_in_valid = 1'b0;
        chk("age_rsp_resumes", 256'(grant_log[grant_log.size()-1]), 256'(2'd1));
        repeat (3) tick();

        // Order: four CPU requests with toggling sel_ready come out in order
        cpu_log.delete();
        for (int i = 0; i < 4; i++) begin
            cpu_req_data = rnd_cpu();
            cpu_req_data[BITS_PER_WORD-1:0] = 32'hA + 32'(i);
            cpu_req_valid = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                sel_ready = ~sel_ready;
                @(negedge clk);
                acc = cpu_req_ready;
                tick();
            end
            chk("order_accept", 256'(acc), 256'(1'b1));
        end
        cpu_req_valid = 1'b0;
        sel_ready = 1'b1;
        repeat (5) tick();
        chk("order_count", 256'(cpu_log.size()), 256'(4));
        for (int i = 0; i < 4 && i < cpu_log.size(); i++)
            chk("order_word", 256'(cpu_log[i]), 256'(32'hA + 32'(i)));

        // Reset mid-traffic with two entries queued
        sel_ready = 1'b0;
        rsp_in_valid = 1'b1; rsp_in_data = rnd_rsp();
        tick();
        rsp_in_data = rnd_rsp();
        tick();
        rsp_in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_readys", 256'({rsp_in_ready, fwd_in_ready, cpu_req_ready}), 256'(3'b111));
        chk("midreset_sel", 256'({sel_valid, sel_kind}), 256'(3'b000));
        tick();
        rst = 1'b1;
        tick();

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rsp_in_valid  = ($urandom_range(0, 2) == 0);
            fwd_in_valid  = ($urandom_range(0, 1) == 0);
            cpu_req_valid = ($urandom_range(0, 1) == 0);
            rsp_in_data = rnd_rsp(); fwd_in_data = rnd_fwd(); cpu_req_data = rnd_cpu();
            fwd_stall = ($urandom_range(0, 3) == 0);
            cpu_stall = ($urandom_range(0, 4) == 0);
            sel_ready = ($urandom_range(0, 3) != 0);
            rst = (c % 700 == 699) ? 1'b0 : 1'b1;
            tick();
        end
        rst = 1'b1;
        idle_inputs();
        sel_ready = 1'b1;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/l2_input_arbiter.md
# l2_input_arbiter

Front-end stage of the L2 cache controller: buffers the three inbound channels (responses from L2/LLC, forwards from LLC, CPU requests from L1) in small per-channel FIFOs. Each cycle it selects at most one message for the L2 core with fixed priority rsp > fwd > cpu. Stall inputs from the core gate the fwd and cpu channels. An aging counter prevents permanent starvation of CPU requests.

## Interface
Parameters:
- ADDR_BITS, 32, CPU request byte address width
- LINE_ADDR_BITS, 28, line address width
- BITS_PER_WORD, 32, word width
- BITS_PER_LINE, 128, line width
- AGE_MAX, 15, number of consecutive lost cycles after which an eligible CPU request is forced through

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- rsp_in_valid / rsp_in_ready  in/out  1/1  response channel handshake
- rsp_in_data  in  `COH_MSG_TYPE_WIDTH+LINE_ADDR_BITS+BITS_PER_LINE+`INVACK_CNT_WIDTH  packed {coh_msg, addr, line, invack_cnt}, MSB first
- fwd_in_valid / fwd_in_ready  in/out  1/1  forward channel handshake
- fwd_in_data  in  `MIX_MSG_TYPE_WIDTH+LINE_ADDR_BITS+`CACHE_ID_WIDTH  packed {coh_msg, addr, req_id}
- cpu_req_valid / cpu_req_ready  in/out  1/1  CPU request handshake
- cpu_req_data  in  `CPU_MSG_TYPE_WIDTH+`HSIZE_WIDTH+`HPROT_WIDTH+ADDR_BITS+BITS_PER_WORD  packed {cpu_msg, hsize, hprot, addr, word}
- fwd_stall  in  1  core cannot accept forwards
- cpu_stall  in  1  core cannot accept CPU requests (reqs buffer full or set conflict)
- sel_valid  out  1  a message is offered to the core
- sel_ready  in  1  core consumes offered message
- sel_kind  out  2  0 none, 1 rsp, 2 fwd, 3 cpu
- sel_rsp_data / sel_fwd_data / sel_cpu_data  out  same widths as inputs  head entry of each FIFO (valid only for channel named by sel_kind)

## Operation
- Three independent 2-entry FIFOs (wr ptr, rd ptr, 2-bit count each). Push when in_valid && in_ready. Pop when sel_valid && sel_ready && sel_kind matches.
- in_ready = (count < 2), derived from registered count only; a pop in the same cycle does not make a full FIFO accept.
- Eligibility: rsp eligible if count_rsp>0; fwd if count_fwd>0 && !fwd_stall; cpu if count_cpu>0 && !cpu_stall.
- Selection (combinational): if cpu eligible and age==AGE_MAX -> cpu; else rsp, then fwd, then cpu, first eligible wins. None eligible -> sel_valid=0, sel_kind=0.
- Age counter (4 bits, saturating at AGE_MAX): increments when cpu eligible and a handshake completes for rsp or fwd; clears to 0 when a cpu pop occurs or cpu not eligible; holds when no handshake occurs (sel_ready low).
- Simultaneous push and pop on same FIFO: count unchanged, both pointers advance.
- sel_*_data always show the FIFO head (rd ptr entry), regardless of selection.

## Timing
- Reset (rst low, async): all counts/pointers/age = 0; all *_ready = 1; sel_valid = 0; sel_kind = 0; storage and sel_*_data = 0.
- Latency: message accepted at edge N is offerable on sel_* in cycle N+1 (no bypass).
- Throughput: 1 message/cycle per channel sustained when sel_ready held high.
- sel_valid/sel_kind may change every cycle with stall inputs; core must sample with sel_ready in the same cycle.
- Reset mid-operation discards all buffered messages; no handshake completes in the reset cycle.

## Test plan
- Reset: assert rst=0 mid-traffic with 2 entries queued -> next cycle all readys 1, sel_valid 0, sel_kind 0.
- Priority: push rsp addr 0x10, fwd addr 0x20, cpu addr 0x300 same cycle, sel_ready=1 -> sel_kind 1,2,3 over cycles N+1,N+2,N+3.
- Stall: fwd queued, fwd_stall=1, cpu queued -> sel_kind 3; drop fwd_stall -> sel_kind 2 next cycle.
- Full: push 3 fwds back-to-back with sel_ready=0 -> fwd_in_ready 0 after second accept; third held until a pop, accepted cycle after pop.
- Aging: cpu queued, continuous rsp stream, sel_ready=1 -> after 15 rsp grants, sel_kind=3 for one cycle, age returns 0, rsp resumes.
- Order: push 4 cpu requests with words 0xA..0xD, sel_ready toggling -> popped in order 0xA,0xB,0xC,0xD, none lost or duplicated.
